// File: rtl/vx_table_pkg.sv
// Shared encodings for the lookup-table initiator: table actions, request ops, FSM states.
package vx_table_pkg;

  localparam logic [2:0] ACT_PRESENT = 3'b000;
  localparam logic [2:0] ACT_ADD     = 3'b001;
  localparam logic [2:0] ACT_UPDATE  = 3'b010;
  localparam logic [2:0] ACT_REMOVE  = 3'b011;
  localparam logic [2:0] ACT_GET     = 3'b100;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00,
    OP_UPSERT = 2'b01,
    OP_DELETE = 2'b10,
    OP_RSVD   = 2'b11
  } req_op_e;

  // The strobe engine owns SETUP/STROBE/WAIT; the controller owns IDLE/RESP.
  typedef enum logic [1:0] {
    SB_IDLE   = 2'b00,
    SB_SETUP  = 2'b01,
    SB_STROBE = 2'b10,
    SB_WAIT   = 2'b11
  } strb_state_e;

  typedef enum logic [1:0] {
    CTL_IDLE = 2'b00,
    CTL_BUSY = 2'b01,
    CTL_RESP = 2'b10
  } ctl_state_e;

  typedef enum logic {
    PH_PROBE = 1'b0,
    PH_ACT   = 1'b1
  } phase_e;

endpackage

// File: rtl/vx_table_strobe.sv
// One table action: SETUP (valid), STROBE (ready pulse), WAIT until done; 3 cycles minimum.
// start_i in WAIT on the done cycle chains straight into SETUP; VX_TABLE_INIT_TIMEOUT_EN bounds WAIT.
module vx_table_strobe
  import vx_table_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic tbl_done_i,
  output logic tbl_valid_o,
  output logic tbl_ready_o,
  output logic done_o,
  output logic timeout_o
);

  strb_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= SB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_IDLE:   if (start_i) state_d = SB_SETUP;
      SB_SETUP:  state_d = SB_STROBE;
      SB_STROBE: state_d = SB_WAIT;
      SB_WAIT:   if (done_o || timeout_o) state_d = start_i ? SB_SETUP : SB_IDLE;
      default:   state_d = SB_IDLE;
    endcase
  end

  always_comb begin
    tbl_valid_o = (state_q != SB_IDLE);
    tbl_ready_o = (state_q == SB_STROBE);
    done_o      = (state_q == SB_WAIT) && tbl_done_i;
  end

`ifdef VX_TABLE_INIT_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // cnt_q holds the number of WAIT cycles already spent without done.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == SB_STROBE)                    cnt_d = '0;
    else if (state_q == SB_WAIT && !tbl_done_i)  cnt_d = cnt_q + 1'b1;
  end

  assign timeout_o = (state_q == SB_WAIT) && !tbl_done_i &&
                     (cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES > 0);
  assign timeout_o  = 1'b0;
`endif

endmodule

// File: rtl/vx_table_initiator.sv
// Expands LOOKUP/UPSERT/DELETE into probe + optional table action; response 4 or 7 cycles after accept.
// One request in flight, req_ready only in IDLE, response held until rsp_ready; VX_TABLE_INIT_TIMEOUT_EN adds WAIT abort.
module vx_table_initiator #(
  parameter int ADDRW          = 4,
  parameter int DATAW          = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DATAW-1:0] req_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic             rsp_err,
  output logic [DATAW-1:0] rsp_data,
  output logic             tbl_valid,
  output logic             tbl_ready,
  output logic [2:0]       tbl_action,
  output logic [ADDRW-1:0] tbl_addr,
  output logic [DATAW-1:0] tbl_data,
  input  logic             tbl_action_out,
  input  logic [DATAW-1:0] tbl_data_out,
  input  logic             tbl_full,
  input  logic             tbl_done
);
  import vx_table_pkg::*;

  typedef struct packed {
    req_op_e          op;
    logic [ADDRW-1:0] addr;
    logic [DATAW-1:0] data;
  } req_t;

  ctl_state_e       state_q, state_d;
  req_t             req_q, req_d;
  phase_e           phase_q, phase_d;
  logic [2:0]       act_q, act_d;
  logic             hit_q, hit_d;
  logic             err_q, err_d;
  logic [DATAW-1:0] rdat_q, rdat_d;
  logic             start;
  logic             sb_done;
  logic             sb_timeout;
  logic             sb_valid;
  logic             sb_ready;

  vx_table_strobe #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_strobe (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start),
    .tbl_done_i (tbl_done),
    .tbl_valid_o(sb_valid),
    .tbl_ready_o(sb_ready),
    .done_o     (sb_done),
    .timeout_o  (sb_timeout)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= CTL_IDLE;
      req_q   <= '0;
      phase_q <= PH_PROBE;
      act_q   <= ACT_PRESENT;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      phase_q <= phase_d;
      act_q   <= act_d;
      hit_q   <= hit_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    phase_d = phase_q;
    act_d   = act_q;
    hit_d   = hit_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    start   = 1'b0;
    case (state_q)
      CTL_IDLE: begin
        if (req_valid) begin
          req_d   = '{op: req_op_e'(req_op), addr: req_addr, data: req_data};
          phase_d = PH_PROBE;
          act_d   = ACT_PRESENT;
          hit_d   = 1'b0;
          err_d   = 1'b0;
          rdat_d  = '0;
          if (req_op_e'(req_op) == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = CTL_RESP;
          end else begin
            start   = 1'b1;
            state_d = CTL_BUSY;
          end
        end
      end
      CTL_BUSY: begin
        if (sb_timeout) begin
          err_d   = 1'b1;
          state_d = CTL_RESP;
        end else if (sb_done && phase_q == PH_PROBE) begin
          hit_d   = tbl_action_out;
          state_d = CTL_RESP;
          case (req_q.op)
            OP_LOOKUP: if (tbl_action_out) act_d = ACT_GET;
            OP_UPSERT: begin
              if (tbl_action_out) act_d = ACT_UPDATE;
              else if (!tbl_full) act_d = ACT_ADD;
              else                err_d = 1'b1;
            end
            OP_DELETE: if (tbl_action_out) act_d = ACT_REMOVE;
            default:   act_d = ACT_PRESENT;
          endcase
          // Any non-probe action chosen above means a second pass through the strobe engine.
          if (act_d != ACT_PRESENT) begin
            phase_d = PH_ACT;
            start   = 1'b1;
            state_d = CTL_BUSY;
          end
        end else if (sb_done) begin
          if (act_q == ACT_GET) rdat_d = tbl_data_out;
          state_d = CTL_RESP;
        end
      end
      CTL_RESP: if (rsp_ready) state_d = CTL_IDLE;
      default:  state_d = CTL_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state_q == CTL_IDLE);
    rsp_valid  = (state_q == CTL_RESP);
    rsp_hit    = hit_q;
    rsp_err    = err_q;
    rsp_data   = rdat_q;
    tbl_valid  = sb_valid;
    tbl_ready  = sb_ready;
    tbl_action = act_q;
    tbl_addr   = req_q.addr;
    tbl_data   = req_q.data;
  end

endmodule

// File: tb/tb_vx_table_initiator.sv
// Bench for vx_table_initiator: 4-entry table model, key/value reference, directed steps then random traffic.
// Define VX_TABLE_INIT_TIMEOUT_EN for both RTL and bench to cover the WAIT timeout.
module tb_vx_table_initiator;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_addr = 4'h0;
  logic [3:0] req_data = 4'h0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_hit;
  logic       rsp_err;
  logic [3:0] rsp_data;
  logic       tbl_valid;
  logic       tbl_ready;
  logic [2:0] tbl_action;
  logic [3:0] tbl_addr;
  logic [3:0] tbl_data;
  logic       tbl_action_out = 1'b0;
  logic [3:0] tbl_data_out = 4'h0;
  logic       tbl_full;
  logic       tbl_done = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vx_table_initiator #(.ADDRW(4), .DATAW(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .tbl_valid(tbl_valid), .tbl_ready(tbl_ready), .tbl_action(tbl_action),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .tbl_action_out(tbl_action_out), .tbl_data_out(tbl_data_out),
    .tbl_full(tbl_full), .tbl_done(tbl_done)
  );

  // Associative table model: acts on each rising edge of tbl_ready, done after done_dly cycles.
  logic       tv_vld [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  logic [3:0] tv_key [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [3:0] tv_dat [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic       rdy_prev = 1'b0;
  int         dcnt = 0;
  int         done_dly = 0;
  bit         stuck = 1'b0;
  logic [2:0] act_log [$];
  logic [3:0] addr_log [$];

  function automatic int tfind(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (tv_vld[i] && tv_key[i] == a) return i;
    return -1;
  endfunction

  function automatic int tfree();
    for (int i = 0; i < 4; i++) if (!tv_vld[i]) return i;
    return -1;
  endfunction

  assign tbl_full = tv_vld[0] & tv_vld[1] & tv_vld[2] & tv_vld[3];

  always @(posedge clk) begin
    rdy_prev <= tbl_ready;
    if (tbl_ready && !rdy_prev) begin
      act_log.push_back(tbl_action);
      addr_log.push_back(tbl_addr);
      case (tbl_action)
        3'b000: tbl_action_out <= (tfind(tbl_addr) >= 0);
        3'b001: if (tfree() >= 0) begin
          tv_vld[tfree()] <= 1'b1;
          tv_key[tfree()] <= tbl_addr;
          tv_dat[tfree()] <= tbl_data;
        end
        3'b010: if (tfind(tbl_addr) >= 0) tv_dat[tfind(tbl_addr)] <= tbl_data;
        3'b011: if (tfind(tbl_addr) >= 0) tv_vld[tfind(tbl_addr)] <= 1'b0;
        3'b100: if (tfind(tbl_addr) >= 0) tbl_data_out <= tv_dat[tfind(tbl_addr)];
        default: tbl_action_out <= 1'b0;
      endcase
      if (stuck)              tbl_done <= 1'b0;
      else if (done_dly == 0) tbl_done <= 1'b1;
      else begin
        tbl_done <= 1'b0;
        dcnt     <= done_dly;
      end
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) tbl_done <= 1'b1;
    end
  end

  // Reference: key -> payload map with capacity 4.
  logic [3:0] mdl [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    chk({pfx, "_req_ready"},  32'(req_ready), 32'd1);
    chk({pfx, "_rsp_valid"},  32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_hit"},    32'(rsp_hit), 32'd0);
    chk({pfx, "_rsp_err"},    32'(rsp_err), 32'd0);
    chk({pfx, "_rsp_data"},   32'(rsp_data), 32'd0);
    chk({pfx, "_tbl_valid"},  32'(tbl_valid), 32'd0);
    chk({pfx, "_tbl_ready"},  32'(tbl_ready), 32'd0);
    chk({pfx, "_tbl_action"}, 32'(tbl_action), 32'd0);
    chk({pfx, "_tbl_addr"},   32'(tbl_addr), 32'd0);
    chk({pfx, "_tbl_data"},   32'(tbl_data), 32'd0);
  endtask

  task automatic run_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] d,
                         input int dly, input int stall);
    logic       eh, ee;
    logic [3:0] ed;
    logic [2:0] ea;
    int         en, elat, lat;
    bit         found;
    eh = 1'b0; ee = 1'b0; ed = 4'h0; ea = 3'b000; en = 1;
    case (op)
      2'b00: if (mdl.exists(int'(a))) begin eh = 1'b1; ed = mdl[int'(a)]; en = 2; ea = 3'b100; end
      2'b01: begin
        if (mdl.exists(int'(a)))  begin eh = 1'b1; en = 2; ea = 3'b010; mdl[int'(a)] = d; end
        else if (mdl.num() < 4)   begin en = 2; ea = 3'b001; mdl[int'(a)] = d; end
        else                      ee = 1'b1;
      end
      2'b10: if (mdl.exists(int'(a))) begin eh = 1'b1; en = 2; ea = 3'b011; mdl.delete(int'(a)); end
      default: begin ee = 1'b1; en = 0; end
    endcase
    // Each table action costs SETUP+STROBE+WAIT, WAIT stretched by the done delay.
    elat = (en == 0) ? 1 : (3 * en + 1 + en * dly);

    done_dly = dly;
    act_log.delete();
    addr_log.delete();
    @(negedge clk);
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = a; req_data = d;
    @(posedge clk);
    found = 1'b0; lat = 0;
    for (int k = 1; k <= 200 && !found; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (!found && rsp_valid) begin found = 1'b1; lat = k; end
    end
    chk("rsp_seen", 32'(found), 32'd1);
    if (found) begin
      chk("latency",  32'(lat), 32'(elat));
      chk("rsp_hit",  32'(rsp_hit), 32'(eh));
      chk("rsp_err",  32'(rsp_err), 32'(ee));
      chk("rsp_data", 32'(rsp_data), 32'(ed));
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (stall > 0) begin
        rsp_ready = 1'b0;
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          chk("hold_valid", 32'(rsp_valid), 32'd1);
          chk("hold_hit",   32'(rsp_hit), 32'(eh));
          chk("hold_err",   32'(rsp_err), 32'(ee));
          chk("hold_data",  32'(rsp_data), 32'(ed));
          chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
      end
      @(negedge clk);
      chk("rsp_drop", 32'(rsp_valid), 32'd0);
      chk("req_ready_back", 32'(req_ready), 32'd1);
    end
    chk("n_strobes", 32'(act_log.size()), 32'(en));
    if (act_log.size() >= 1) begin
      chk("probe_action", 32'(act_log[0]), 32'd0);
      chk("probe_addr",   32'(addr_log[0]), 32'(a));
    end
    if (act_log.size() >= 2 && en == 2) chk("act_action", 32'(act_log[1]), 32'(ea));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: observed=no finish expected=finish within budget");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rop;
    int         r;
    repeat (2) @(negedge clk);
    check_reset("reset");
    reset = 1'b1;
    @(negedge clk);

    run_req(2'b01, 4'h3, 4'hA, 0, 0);   // add into empty table
    run_req(2'b00, 4'h3, 4'h0, 0, 0);   // hit, returns A after 7 cycles
    run_req(2'b01, 4'h3, 4'h5, 0, 0);   // update existing
    run_req(2'b00, 4'h3, 4'h0, 0, 0);
    run_req(2'b10, 4'h2, 4'h0, 0, 0);   // delete absent key
    run_req(2'b01, 4'h0, 4'h1, 0, 0);
    run_req(2'b01, 4'h1, 4'h2, 0, 0);
    run_req(2'b01, 4'h2, 4'h3, 1, 0);
    run_req(2'b01, 4'h9, 4'h7, 0, 0);   // table full
    run_req(2'b10, 4'h2, 4'h0, 0, 0);   // delete present key
    run_req(2'b00, 4'h2, 4'h0, 0, 0);   // now misses
    run_req(2'b11, 4'h4, 4'h4, 0, 0);   // reserved op
    run_req(2'b00, 4'h1, 4'h0, 0, 5);   // response stalled 5 cycles

    // Reset while the probe sits in WAIT.
    done_dly = 3;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 4'h3; req_data = 4'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_tbl_valid", 32'(tbl_valid), 32'd1);
    chk("pre_rst_tbl_ready", 32'(tbl_ready), 32'd0);
    chk("pre_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_reset("rst_wait");
    reset = 1'b1;
    repeat (5) @(negedge clk);
    done_dly = 0;

`ifdef VX_TABLE_INIT_TIMEOUT_EN
    begin
      int  lat;
      bit  found;
      stuck = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_op = 2'b00; req_addr = 4'h3; req_data = 4'h0;
      @(posedge clk);
      found = 1'b0; lat = 0;
      for (int k = 1; k <= 100 && !found; k++) begin
        @(negedge clk);
        req_valid = 1'b0;
        if (!found && rsp_valid) begin found = 1'b1; lat = k; end
      end
      chk("tmo_seen", 32'(found), 32'd1);
      chk("tmo_latency", 32'(lat), 32'd19);
      chk("tmo_err", 32'(rsp_err), 32'd1);
      chk("tmo_hit", 32'(rsp_hit), 32'd0);
      chk("tmo_data", 32'(rsp_data), 32'd0);
      @(negedge clk);
      chk("tmo_drop", 32'(rsp_valid), 32'd0);
      stuck = 1'b0;
    end
`endif

    for (int i = 0; i < 40; i++) begin
      r   = int'($urandom_range(0, 9));
      rop = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      run_req(rop, 4'($urandom_range(0, 7)), 4'($urandom), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
